// File: rtl/measurement_stream_parser_if.sv
// Byte ingress and round egress handshakes of the measurement stream parser.
// The master modport is the parser's view; the slave modport is the surrounding FIFO/decoder.
interface measurement_stream_parser_if #(
  parameter int unsigned PU_PER_ROUND = 4,
  parameter int unsigned U_BIT_WIDTH  = 3
);
  logic [7:0]              input_data;
  logic                    input_valid;
  logic                    input_ready;
  logic [PU_PER_ROUND-1:0] round_data;
  logic [U_BIT_WIDTH-1:0]  round_index;
  logic                    round_last;
  logic                    round_valid;
  logic                    round_ready;

  modport master (
    input  input_data,
    input  input_valid,
    output input_ready,
    output round_data,
    output round_index,
    output round_last,
    output round_valid,
    input  round_ready
  );

  modport slave (
    output input_data,
    output input_valid,
    input  input_ready,
    input  round_data,
    input  round_index,
    input  round_last,
    input  round_valid,
    output round_ready
  );
endinterface

// File: rtl/measurement_stream_parser.sv
// Parses the host byte stream (start command, per-syndrome header, padded payload) and
// reassembles one measurement word per round for the PU-array round loader.
module measurement_stream_parser #(
  parameter int unsigned GRID_WIDTH_X = 4,
  parameter int unsigned GRID_WIDTH_Z = 1,
  parameter int unsigned GRID_WIDTH_U = 5,
  parameter logic [7:0]  START_MSG    = 8'h01,
  parameter logic [7:0]  MEAS_HDR     = 8'h02
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        decoder_busy,
  output logic                        decode_start,
  output logic [7:0]                  drop_count,
  measurement_stream_parser_if.master bus
);
  localparam int unsigned PU_PER_ROUND    = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int unsigned BYTES_PER_ROUND = (PU_PER_ROUND + 7) >> 3;
  localparam int unsigned U_BIT_WIDTH     = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
  localparam int unsigned CNT_WIDTH       = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
  localparam int unsigned ASM_WIDTH       = BYTES_PER_ROUND * 8;

  localparam logic [CNT_WIDTH-1:0]   LastByte  = CNT_WIDTH'(BYTES_PER_ROUND - 1);
  localparam logic [U_BIT_WIDTH-1:0] LastRound = U_BIT_WIDTH'(GRID_WIDTH_U - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitHdr = 2'd1;
  localparam logic [1:0] StCollect = 2'd2;
  localparam logic [1:0] StEmit    = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [CNT_WIDTH-1:0]    byte_cnt_q, byte_cnt_d;
  logic [ASM_WIDTH-1:0]    asm_q, asm_d, asm_merged;
  logic [PU_PER_ROUND-1:0] round_data_q, round_data_d;
  logic [U_BIT_WIDTH-1:0]  round_index_q, round_index_d;
  logic                    round_last_q, round_last_d;
  logic                    round_valid_q, round_valid_d;
  logic                    decode_start_q, decode_start_d;
  logic [7:0]              drop_q, drop_d, drop_inc;
  logic                    accept;

  // Header accept is the only point where a busy decoder can hold the stream back.
  assign bus.input_ready = (state_q == StIdle) || (state_q == StCollect) ||
                           ((state_q == StWaitHdr) && !decoder_busy);
  assign accept          = bus.input_valid && bus.input_ready;
  assign drop_inc        = drop_q + {7'd0, (drop_q != 8'hFF)};

  always_comb begin
    asm_merged = asm_q;
    asm_merged[{byte_cnt_q, 3'b000} +: 8] = bus.input_data;
  end

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    round_data_d   = round_data_q;
    round_index_d  = round_index_q;
    round_last_d   = round_last_q;
    round_valid_d  = round_valid_q;
    decode_start_d = 1'b0;
    drop_d         = drop_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.input_data == START_MSG) state_d = StWaitHdr;
          else                             drop_d  = drop_inc;
        end
      end
      StWaitHdr: begin
        if (accept) begin
          if (bus.input_data == MEAS_HDR) begin
            state_d       = StCollect;
            byte_cnt_d    = '0;
            asm_d         = '0;
            round_index_d = '0;
            round_last_d  = (LastRound == '0);
          end else begin
            drop_d = drop_inc;
          end
        end
      end
      StCollect: begin
        if (accept) begin
          if (byte_cnt_q == LastByte) begin
            // Padding bits above PU_PER_ROUND fall off here.
            round_data_d  = asm_merged[PU_PER_ROUND-1:0];
            round_valid_d = 1'b1;
            byte_cnt_d    = '0;
            asm_d         = '0;
            state_d       = StEmit;
          end else begin
            asm_d      = asm_merged;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      StEmit: begin
        if (bus.round_ready) begin
          round_valid_d = 1'b0;
          if (round_last_q) begin
            decode_start_d = 1'b1;
            round_index_d  = '0;
            round_last_d   = (LastRound == '0);
            state_d        = StWaitHdr;
          end else begin
            round_index_d = round_index_q + 1'b1;
            round_last_d  = (round_index_d == LastRound);
            state_d       = StCollect;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      byte_cnt_q     <= '0;
      asm_q          <= '0;
      round_data_q   <= '0;
      round_index_q  <= '0;
      round_last_q   <= 1'b0;
      round_valid_q  <= 1'b0;
      decode_start_q <= 1'b0;
      drop_q         <= 8'd0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
      round_data_q   <= round_data_d;
      round_index_q  <= round_index_d;
      round_last_q   <= round_last_d;
      round_valid_q  <= round_valid_d;
      decode_start_q <= decode_start_d;
      drop_q         <= drop_d;
    end
  end

  assign bus.round_data  = round_data_q;
  assign bus.round_index = round_index_q;
  assign bus.round_last  = round_last_q;
  assign bus.round_valid = round_valid_q;
  assign decode_start    = decode_start_q;
  assign drop_count      = drop_q;
endmodule

// File: tb/tb_measurement_stream_parser.sv
// Scoreboard bench for measurement_stream_parser: a byte-level protocol model predicts rounds,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_measurement_stream_parser;
  localparam int unsigned X   = 4;
  localparam int unsigned Z   = 1;
  localparam int unsigned U   = 5;
  localparam int unsigned PU  = X * Z;
  localparam int unsigned BPR = (PU + 7) / 8;
  localparam int unsigned UW  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       decoder_busy = 1'b0;
  logic       decode_start;
  logic [7:0] drop_count;

  measurement_stream_parser_if #(.PU_PER_ROUND(PU), .U_BIT_WIDTH(UW)) bus ();

  measurement_stream_parser #(
    .GRID_WIDTH_X(X),
    .GRID_WIDTH_Z(Z),
    .GRID_WIDTH_U(U),
    .START_MSG   (8'h01),
    .MEAS_HDR    (8'h02)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .decoder_busy(decoder_busy),
    .decode_start(decode_start),
    .drop_count  (drop_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PU-1:0] data;
    int            idx;
    bit            last;
  } rnd_t;

  rnd_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Protocol model: 0 = waiting for start, 1 = waiting for header, 2 = collecting payload
  int m_mode, m_bytes, m_round, m_drops;
  logic [8*BPR-1:0] m_asm;

  bit rand_ready = 0, rand_busy = 0, rand_gap = 0, busy_force = 0;
  bit stall_armed = 0, ds_pending = 0;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_bytes = 0; m_round = 0; m_drops = 0; m_asm = '0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    rnd_t r;
    case (m_mode)
      0: if (b == 8'h01) m_mode = 1; else m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      1: begin
        if (b == 8'h02) begin
          m_mode = 2; m_bytes = 0; m_round = 0; m_asm = '0;
        end else begin
          m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        end
      end
      default: begin
        m_asm[8*m_bytes +: 8] = b;
        m_bytes++;
        if (m_bytes == BPR) begin
          r.data = m_asm[PU-1:0];
          r.idx  = m_round;
          r.last = (m_round == U - 1);
          exp_q.push_back(r);
          m_bytes = 0; m_asm = '0; m_round++;
          if (m_round == U) m_mode = 1;
        end
      end
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.input_data  = b;
    bus.input_valid = 1'b1;
    @(negedge clk);
    while (!bus.input_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!bus.input_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      bus.input_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_byte(b);
    #1;
    bus.input_valid = 1'b0;
    if (rand_gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((exp_q.size() != 0 || bus.round_valid) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check("drain_timeout", 32'd1, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_round_valid", 32'(bus.round_valid), 32'd0);
    check("rst_round_data", 32'(bus.round_data), 32'd0);
    check("rst_round_index", 32'(bus.round_index), 32'd0);
    check("rst_round_last", 32'(bus.round_last), 32'd0);
    check("rst_decode_start", 32'(decode_start), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_input_ready", 32'(bus.input_ready), 32'd1);
  endtask

  task automatic send_syndrome(input logic [7:0] p0, p1, p2, p3, p4);
    send_byte(8'h02);
    send_byte(p0); send_byte(p1); send_byte(p2); send_byte(p3); send_byte(p4);
  endtask

  always begin
    @(posedge clk); #1;
    if (stall_armed && bus.round_valid && bus.round_index == 3'd2 && stall_cnt < 10) begin
      bus.round_ready = 1'b0;
      stall_cnt++;
    end else if (rand_ready) begin
      bus.round_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.round_ready = 1'b1;
    end
  end

  always begin
    @(posedge clk); #2;
    decoder_busy = rand_busy ? 1'($urandom_range(0, 1)) : busy_force;
  end

  always @(negedge clk) begin
    rnd_t r;
    if (reset) begin
      ds_pending = 0;
    end else begin
      if (ds_pending || decode_start) check("decode_start", 32'(decode_start), 32'(ds_pending));
      ds_pending = 0;
      if (bus.round_valid) begin
        check("input_ready_in_emit", 32'(bus.input_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_round", 32'd1, 32'd0);
        end else if (bus.round_ready) begin
          r = exp_q.pop_front();
          check("round_data", 32'(bus.round_data), 32'(r.data));
          check("round_index", 32'(bus.round_index), 32'(r.idx));
          check("round_last", 32'(bus.round_last), 32'(r.last));
          if (r.last) ds_pending = 1;
        end else begin
          check("held_data", 32'(bus.round_data), 32'(exp_q[0].data));
          check("held_index", 32'(bus.round_index), 32'(exp_q[0].idx));
        end
      end
    end
  end

  initial begin
    bus.input_data  = 8'h00;
    bus.input_valid = 1'b0;
    bus.round_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();

    // Garbage in IDLE, stray start in WAIT_HDR, then the nominal syndrome
    send_byte(8'h55);
    send_byte(8'h02);
    check("drop_idle", 32'(drop_count), 32'd2);
    send_byte(8'h01);
    send_byte(8'h01);
    check("drop_wait_hdr", 32'(drop_count), 32'd3);
    send_syndrome(8'h03, 8'h00, 8'h0A, 8'h00, 8'h01);
    wait_drained();
    check("drop_after_nominal", 32'(drop_count), 32'(m_drops));

    // Header held off by a busy decoder; repeat syndrome with padding, in-band 02, stall
    stall_armed = 1; stall_cnt = 0;
    busy_force = 1;
    bus.input_data = 8'h02;
    bus.input_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("hdr_gated", 32'(bus.input_ready), 32'd0);
    end
    @(posedge clk); #1;
    busy_force = 0;
    send_syndrome(8'hF5, 8'h02, 8'h03, 8'h5A, 8'hFF);
    wait_drained();
    check("stall_applied", 32'(stall_cnt), 32'd10);
    stall_armed = 0;

    // Reset after round 1 has been emitted
    send_byte(8'h02); send_byte(8'h7C); send_byte(8'h08);
    wait_drained();
    do_reset();
    check_reset_state();
    send_byte(8'h02);
    check("drop_after_reset", 32'(drop_count), 32'd1);
    repeat (260) send_byte(8'h9C);
    check("drop_saturate", 32'(drop_count), 32'd255);
    send_byte(8'h01);
    send_syndrome(8'h06, 8'h09, 8'h0C, 8'hE3, 8'h0F);
    wait_drained();

    // Randomized traffic, random backpressure and busy toggling
    do_reset();
    rand_ready = 1; rand_busy = 1; rand_gap = 1;
    repeat ($urandom_range(1, 4)) begin
      logic [7:0] g;
      g = 8'($urandom_range(0, 255));
      if (g == 8'h01) g = 8'h00;
      send_byte(g);
    end
    send_byte(8'h01);
    for (int s = 0; s < 6; s++) begin
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] g;
        g = 8'($urandom_range(0, 255));
        if (g == 8'h02) g = 8'h03;
        send_byte(g);
      end
      send_byte(8'h02);
      for (int k = 0; k < int'(U * BPR); k++) send_byte(8'($urandom_range(0, 255)));
      wait_drained();
      check("drop_random", 32'(drop_count), 32'(m_drops));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
